fp_div_iter: RTL and testbench

Parametrised, iterative floating-point divider; the successor to the single-cycle bfloat16 divider. It computes c = a / b for any sign/exponent/mantissa split (bfloat16 by default) using a radix-2 restoring loop, one quotient bit per clock. It adds valid/ready handshakes on both sides, IEEE-style special-case handling and exception flags. It sits between the operand register stage and the result writeback of the bfloat arithmetic datapath.

---
 rtl/fp_div_iter.sv | 192 +++++++++++++++++++
 tb/tb_fp_div_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Iterative radix-2 restoring floating-point divider (one quotient bit per clock) with
// valid/ready handshakes and {inv,dz,ovf,unf} flags. Define FDIV_RNE_EN for round-to-nearest-even.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] c,
  output logic [3:0]           flags,
  output logic [2:0]           dbg_state
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q     = MAN_W + 3;
  localparam int CNT_W = $clog2(Q);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;

  localparam logic [EXP_W+1:0] BIAS_E = (EXP_W+2)'(BIAS);
  localparam logic [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
  localparam logic [EXP_W:0]   EMAX_E = (EXP_W+1)'(EMAX);
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: operands transfer on a clock edge where in_valid && in_ready; the result
  // is presented with out_valid and held stable until an edge where out_valid && out_ready.
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_NORM, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0]              flags_q, flags_d;
  logic                    sc_q, sc_d;
  logic signed [EXP_W+1:0] e_q, e_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W:0]          div_q, div_d;
  logic [Q-1:0]            quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    sa, sb;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                    ge, msb;
  logic signed [EXP_W+1:0] e_n;
  logic [MAN_W-1:0]        mant;
`ifdef FDIV_RNE_EN
  logic                    guard, rnd, sticky;
  logic [MAN_W:0]          mant_r;
`endif

  assign {sa, ea, ma} = a_q;
  assign {sb, eb, mb} = b_q;
  // Subnormals are flushed: a zero exponent is treated as zero whatever the mantissa.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (ma == '0);
  assign b_inf  = (&eb) && (mb == '0);
  assign a_nan  = (&ea) && (ma != '0);
  assign b_nan  = (&eb) && (mb != '0);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    flags_d = flags_q;
    sc_d    = sc_q;
    e_d     = e_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ge      = 1'b0;
    msb     = 1'b0;
    e_n     = e_q;
    mant    = '0;
`ifdef FDIV_RNE_EN
    guard   = 1'b0;
    rnd     = 1'b0;
    sticky  = 1'b0;
    mant_r  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        sc_d    = sa ^ sb;
        state_d = S_DONE;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
          c_d     = QNAN;
          flags_d = 4'b1000;
        end else if (a_inf) begin
          c_d     = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0000;
        end else if (b_zero) begin
          c_d     = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0100;
        end else if (a_zero || b_inf) begin
          c_d     = {sa ^ sb, {(W-1){1'b0}}};
          flags_d = 4'b0000;
        end else begin
          e_d     = {2'b00, ea} - {2'b00, eb} + BIAS_E;
          rem_d   = {1'b0, 1'b1, ma};
          div_d   = {1'b1, mb};
          quo_d   = '0;
          cnt_d   = CNT_W'(Q - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Compare before doubling so the first quotient bit carries the integer weight.
        ge    = (rem_q >= {1'b0, div_q});
        rem_d = (ge ? rem_q - {1'b0, div_q} : rem_q) << 1;
        quo_d = {quo_q[Q-2:0], ge};
        if (cnt_q == '0) state_d = S_NORM;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_NORM: begin
        msb  = quo_q[Q-1];
        e_n  = msb ? e_q : e_q - E_ONE;
        mant = msb ? quo_q[Q-2:2] : quo_q[Q-3:1];
`ifdef FDIV_RNE_EN
        guard  = msb ? quo_q[1] : quo_q[0];
        rnd    = msb & quo_q[0];
        sticky = |rem_q;
        mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, guard & (rnd | sticky | mant[0])};
        mant   = mant_r[MAN_W-1:0];
        e_n    = e_n + {{(EXP_W+1){1'b0}}, mant_r[MAN_W]};
`endif
        if (!e_n[EXP_W+1] && (e_n[EXP_W:0] >= EMAX_E)) begin
          c_d     = {sc_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0010;
        end else if (e_n[EXP_W+1] || (e_n == '0)) begin
          c_d     = {sc_q, {(W-1){1'b0}}};
          flags_d = 4'b0001;
        end else begin
          c_d     = {sc_q, e_n[EXP_W-1:0], mant};
          flags_d = 4'b0000;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      sc_q    <= 1'b0;
      e_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      flags_q <= flags_d;
      sc_q    <= sc_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter (bfloat16): directed cases, backpressure, reset abort, and random
// operands compared against an exact-rational reference divider.
module tb_fp_div_iter;
  localparam int NORM_LAT = 12;
  localparam int SPEC_LAT = 1;
  localparam int TMO      = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid;
  logic [15:0] c;
  logic [3:0]  flags;
  logic [2:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  fp_div_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .flags(flags), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient of the significands scaled by 2^20, then normalise and round.
  function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] rc, output logic [3:0] rf, output int rlat);
    int     ex, ey, mx, my, e, p, sh;
    longint num, den, q, r, mant;
`ifdef FDIV_RNE_EN
    longint disc, half, lhs, rhs;
`endif
    logic   s, xz, yz, xi, yi, xn, yn;
    ex = int'(x[14:7]); mx = int'(x[6:0]);
    ey = int'(y[14:7]); my = int'(y[6:0]);
    xz = (ex == 0); xi = (ex == 255) && (mx == 0); xn = (ex == 255) && (mx != 0);
    yz = (ey == 0); yi = (ey == 255) && (my == 0); yn = (ey == 255) && (my != 0);
    s = x[15] ^ y[15];
    rf = 4'b0000;
    rlat = SPEC_LAT;
    if (xn || yn || (xi && yi) || (xz && yz)) begin
      rc = 16'h7FC0; rf = 4'b1000;
    end else if (xi) begin
      rc = {s, 8'hFF, 7'h00};
    end else if (yz) begin
      rc = {s, 8'hFF, 7'h00}; rf = 4'b0100;
    end else if (xz || yi) begin
      rc = {s, 15'h0000};
    end else begin
      rlat = NORM_LAT;
      num  = longint'(128 + mx) << 20;
      den  = longint'(128 + my);
      q    = num / den;
      r    = num % den;
      p    = (q >= (longint'(1) << 20)) ? 20 : 19;
      e    = ex - ey + 127 + p - 20;
      sh   = p - 7;
      mant = q >> sh;
`ifdef FDIV_RNE_EN
      disc = q - (mant << sh);
      half = longint'(1) << (sh - 1);
      lhs  = disc * den + r;
      rhs  = half * den;
      if (lhs > rhs || (lhs == rhs && mant[0])) mant = mant + 1;
      if (mant == 256) begin mant = 128; e = e + 1; end
`endif
      if (e >= 255) begin
        rc = {s, 8'hFF, 7'h00}; rf = 4'b0010;
      end else if (e <= 0) begin
        rc = {s, 15'h0000}; rf = 4'b0001;
      end else begin
        rc = {s, 8'(e), 7'(mant)};
      end
    end
  endfunction

  function automatic logic [15:0] rand_op();
    int         k;
    logic [7:0] e;
    logic [6:0] m;
    k = int'($urandom_range(0, 15));
    m = 7'($urandom);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       begin e = 8'hFF; m = 7'h00; end
      3, 4:    e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(96, 158));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Called at accept edge + 1; counts edges until out_valid, bounded by TMO.
  task automatic wait_result(input string tag, input logic [15:0] ec, input logic [3:0] ef,
                             input int elat);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " c"}, 32'(c), 32'(ec));
    check({tag, " flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] ec,
                       input logic [3:0] ef, input int elat, input int hold, input string tag);
    a = ta; b = tb_v; in_valid = 1'b1;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    wait_result(tag, ec, ef, elat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held c"}, 32'(c), 32'(ec));
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] x, y, rc;
    logic [3:0]  rf;
    int          rlat;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset c", 32'(c), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, NORM_LAT, 0, "6div2");
`ifdef FDIV_RNE_EN
    do_op(16'h3F80, 16'h4040, 16'h3EAB, 4'b0000, NORM_LAT, 0, "1div3");
`else
    do_op(16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, NORM_LAT, 0, "1div3");
`endif
    do_op(16'h3F80, 16'h0000, 16'h7F80, 4'b0100, SPEC_LAT, 0, "pos_dz");
    do_op(16'hBF80, 16'h0000, 16'hFF80, 4'b0100, SPEC_LAT, 0, "neg_dz");
    do_op(16'h0000, 16'h0000, 16'h7FC0, 4'b1000, SPEC_LAT, 0, "zero_zero");
    do_op(16'h7F80, 16'h7F80, 16'h7FC0, 4'b1000, SPEC_LAT, 0, "inf_inf");
    do_op(16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000, SPEC_LAT, 0, "nan_in");
    do_op(16'hFF80, 16'h4000, 16'hFF80, 4'b0000, SPEC_LAT, 0, "inf_fin");
    do_op(16'h4000, 16'hFF80, 16'h8000, 4'b0000, SPEC_LAT, 0, "fin_inf");
    do_op(16'h7F7F, 16'h0080, 16'h7F80, 4'b0010, NORM_LAT, 0, "ovf");
    do_op(16'h0080, 16'h4000, 16'h0000, 4'b0001, NORM_LAT, 0, "unf");

    // Backpressure: result held with a competing in_valid that must not be taken.
    a = 16'h3F80; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp first", 16'h3F00, 4'b0000, NORM_LAT);
    a = 16'h4040; b = 16'h3F80; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp c", 32'(c), 32'h3F00);
      check("bp flags", 32'(flags), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accepted", 32'(in_ready), 32'd0);
    wait_result("bp second", 16'h4040, 4'b0000, NORM_LAT);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset four edges after accept: everything clears before the next clock edge.
    a = 16'h3F80; b = 16'h4040; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort c", 32'(c), 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, NORM_LAT, 0, "after abort");

    for (int n = 0; n < 300; n++) begin
      x = rand_op();
      y = rand_op();
      ref_div(x, y, rc, rf, rlat);
      do_op(x, y, rc, rf, rlat, int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
